// File: rtl/ddr_odt_lane_ctrl.sv
// ODT lane controller: per-rank ODT windows serialised into 4:1 TX/OE nibbles,
// plus a delay-line sequencer that walks every channel's IOD tap to a target.
module ddr_odt_lane_ctrl #(
  parameter int unsigned NUM_ODT    = 2,
  parameter int unsigned LAT_W      = 5,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned TAP_W      = 8,
  parameter int unsigned LOAD_TAP   = 1,
  parameter int unsigned MAX_TAP    = 127,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                       i_fab_clk,
  input  logic                       i_tx_sync_rst,
  input  logic [NUM_ODT-1:0]         i_odt_req,
  input  logic [1:0]                 i_req_phase,
  input  logic [LAT_W-1:0]           i_cfg_odt_lat,
  input  logic [LEN_W-1:0]           i_cfg_odt_len,
  output logic                       o_odt_idle,
  output logic [4*NUM_ODT-1:0]       o_tx_data,
  output logic [4*NUM_ODT-1:0]       o_oe_data,
  input  logic                       i_dly_start,
  input  logic [TAP_W*NUM_ODT-1:0]   i_dly_target,
  output logic                       o_dly_busy,
  output logic                       o_dly_done,
  output logic [NUM_ODT-1:0]         o_dly_err,
  output logic [NUM_ODT-1:0]         o_delay_line_load,
  output logic [NUM_ODT-1:0]         o_delay_line_move,
  output logic [NUM_ODT-1:0]         o_delay_line_direction,
  input  logic [NUM_ODT-1:0]         i_delay_line_out_of_range
);

  // Pending window spans the latest phase a request can reach: phase 3 + max LAT + max LEN - 1.
  localparam int unsigned PEND_W = 3 + ((1 << LAT_W) - 1) + ((1 << LEN_W) - 1);
  localparam int unsigned GAP_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_GAP, S_DONE} state_t;

  // ---------------- ODT windows ----------------
  logic [NUM_ODT-1:0][PEND_W-1:0] r_pend;
  logic [NUM_ODT-1:0][PEND_W-1:0] w_win;
  logic [PEND_W-1:0]              w_mask;
  logic                           w_any;
  int unsigned                    w_start;
  int unsigned                    w_len;
  logic [4*NUM_ODT-1:0]           r_tx;
  logic [4*NUM_ODT-1:0]           r_oe;
  logic                           r_idle;

  // New-request mask relative to phase 0 of the current cycle, ORed onto each channel's pending phases.
  always_comb begin
    w_start = 32'(i_req_phase) + 32'(i_cfg_odt_lat);
    w_len   = (i_cfg_odt_len == '0) ? 32'd1 : 32'(i_cfg_odt_len);
    w_mask  = '0;
    for (int unsigned j = 0; j < PEND_W; j++) begin
      w_mask[j] = (j >= w_start) && (j < w_start + w_len);
    end
    w_any = 1'b0;
    for (int unsigned c = 0; c < NUM_ODT; c++) begin
      w_win[c] = r_pend[c] | (i_odt_req[c] ? w_mask : '0);
      w_any    = w_any | (|w_win[c]);
    end
  end

  // Emit the current cycle's four phases and shift the remainder down by one cycle.
  always_ff @(posedge i_fab_clk) begin
    if (i_tx_sync_rst) begin
      r_pend <= '0;
      r_tx   <= '0;
      r_oe   <= '0;
      r_idle <= 1'b1;
    end else begin
      for (int unsigned c = 0; c < NUM_ODT; c++) begin
        r_tx[4*c +: 4] <= w_win[c][3:0];
        r_pend[c]      <= PEND_W'(w_win[c] >> 4);
      end
      r_oe   <= '1;
      r_idle <= ~w_any;
    end
  end

  assign o_tx_data  = r_tx;
  assign o_oe_data  = r_oe;
  assign o_odt_idle = r_idle;

  // ---------------- Delay-line sequencer ----------------
  state_t                        r_state, w_nxt_state;
  logic [NUM_ODT-1:0][TAP_W-1:0] r_tgt, w_nxt_tgt;
  logic [NUM_ODT-1:0][TAP_W-1:0] r_cur, w_nxt_cur;
  logic [NUM_ODT-1:0]            r_err, w_nxt_err;
  logic [NUM_ODT-1:0]            r_dir, w_nxt_dir;
  logic [NUM_ODT-1:0]            r_move, w_nxt_move;
  logic [NUM_ODT-1:0]            r_load;
  logic                          r_busy, r_done;
  logic [GAP_W-1:0]              r_gap, w_nxt_gap;
  logic                          w_eval;
  logic [NUM_ODT-1:0]            w_eval_err;
  logic [NUM_ODT-1:0]            w_need;

  // Next state; outputs are registered from the next state so they line up with the state's own cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_tgt   = r_tgt;
    w_nxt_cur   = r_cur;
    w_nxt_err   = r_err;
    w_nxt_dir   = r_dir;
    w_nxt_move  = '0;
    w_nxt_gap   = r_gap;
    w_eval      = 1'b0;
    w_eval_err  = r_err;
    w_need      = '0;
    case (r_state)
      S_IDLE: begin
        if (i_dly_start) begin
          w_nxt_state = S_LOAD;
          w_nxt_tgt   = i_dly_target;
          for (int unsigned c = 0; c < NUM_ODT; c++) begin
            w_nxt_cur[c] = TAP_W'(LOAD_TAP);
            w_nxt_err[c] = 32'(i_dly_target[c*TAP_W +: TAP_W]) > MAX_TAP;
          end
        end
      end
      S_LOAD: w_eval = 1'b1;
      S_STEP: begin
        w_nxt_state = S_GAP;
        w_nxt_gap   = GAP_W'(SETTLE_CYC - 1);
      end
      S_GAP: begin
        if (r_gap != '0) begin
          w_nxt_gap = r_gap - GAP_W'(1);
        end else begin
          w_nxt_err  = r_err | i_delay_line_out_of_range;
          w_eval_err = w_nxt_err;
          w_eval     = 1'b1;
        end
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
    if (w_eval) begin
      for (int unsigned c = 0; c < NUM_ODT; c++) begin
        w_need[c] = !w_eval_err[c] && (r_cur[c] != r_tgt[c]);
      end
      if (|w_need) begin
        w_nxt_state = S_STEP;
        w_nxt_move  = w_need;
        for (int unsigned c = 0; c < NUM_ODT; c++) begin
          if (w_need[c]) begin
            w_nxt_dir[c] = r_tgt[c] > r_cur[c];
            w_nxt_cur[c] = w_nxt_dir[c] ? (r_cur[c] + TAP_W'(1)) : (r_cur[c] - TAP_W'(1));
          end
        end
      end else begin
        w_nxt_state = S_DONE;
      end
    end
  end

  // Sequencer state, tap counters and registered IOD controls.
  always_ff @(posedge i_fab_clk) begin
    if (i_tx_sync_rst) begin
      r_state <= S_IDLE;
      r_tgt   <= '0;
      for (int unsigned c = 0; c < NUM_ODT; c++) r_cur[c] <= TAP_W'(LOAD_TAP);
      r_err   <= '0;
      r_dir   <= '0;
      r_move  <= '0;
      r_load  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gap   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_tgt   <= w_nxt_tgt;
      r_cur   <= w_nxt_cur;
      r_err   <= w_nxt_err;
      r_dir   <= w_nxt_dir;
      r_move  <= w_nxt_move;
      r_load  <= (w_nxt_state == S_LOAD) ? '1 : '0;
      r_busy  <= (w_nxt_state != S_IDLE);
      r_done  <= (w_nxt_state == S_DONE);
      r_gap   <= w_nxt_gap;
    end
  end

  assign o_dly_busy             = r_busy;
  assign o_dly_done             = r_done;
  assign o_dly_err              = r_err;
  assign o_delay_line_load      = r_load;
  assign o_delay_line_move      = r_move;
  assign o_delay_line_direction = r_dir;

endmodule

// File: tb/tb_ddr_odt_lane_ctrl.sv
// Testbench for ddr_odt_lane_ctrl: directed ODT/delay scenarios plus randomized runs
// checked against a phase-map ODT model and a schedule-based delay model.
module tb_ddr_odt_lane_ctrl;
  localparam int unsigned NUM_ODT = 2, LAT_W = 5, LEN_W = 4, TAP_W = 8;
  localparam int unsigned LOAD_TAP = 1, MAX_TAP = 127, S = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_ODT-1:0]       req;
  logic [1:0]               ph;
  logic [LAT_W-1:0]         lat;
  logic [LEN_W-1:0]         len;
  logic                     idle;
  logic [4*NUM_ODT-1:0]     tx, oe;
  logic                     start;
  logic [TAP_W*NUM_ODT-1:0] targ;
  logic                     busy, done;
  logic [NUM_ODT-1:0]       err, load, move, dir, oor;

  int vec = 0;
  int bad = 0;
  bit mark [NUM_ODT][4096];

  ddr_odt_lane_ctrl #(.NUM_ODT(NUM_ODT), .LAT_W(LAT_W), .LEN_W(LEN_W), .TAP_W(TAP_W),
    .LOAD_TAP(LOAD_TAP), .MAX_TAP(MAX_TAP), .SETTLE_CYC(S)) dut (
    .i_fab_clk(clk), .i_tx_sync_rst(rst), .i_odt_req(req), .i_req_phase(ph),
    .i_cfg_odt_lat(lat), .i_cfg_odt_len(len), .o_odt_idle(idle), .o_tx_data(tx),
    .o_oe_data(oe), .i_dly_start(start), .i_dly_target(targ), .o_dly_busy(busy),
    .o_dly_done(done), .o_dly_err(err), .o_delay_line_load(load),
    .o_delay_line_move(move), .o_delay_line_direction(dir),
    .i_delay_line_out_of_range(oor));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; ph = '0; lat = '0; len = '0; start = 1'b0; targ = '0; oor = '0;
    tick();
    vec++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle got %b exp 1", idle); end
    vec++; if (tx !== '0) begin bad++; $display("FAIL rst_tx got %h exp 0", tx); end
    vec++; if (oe !== '0) begin bad++; $display("FAIL rst_oe got %h exp 0", oe); end
    vec++; if ({busy, done, err, load, move, dir} !== '0) begin bad++;
      $display("FAIL rst_dly got %b exp 0", {busy, done, err, load, move, dir}); end
    rst = 1'b0;
    tick();
    vec++; if (oe !== 8'hFF) begin bad++; $display("FAIL rst_oe_on got %h exp ff", oe); end
    vec++; if (idle !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL rst_after got idle=%b busy=%b exp 1 0", idle, busy); end
  endtask

  task automatic test_odt_latency();
    logic [3:0] e0;
    logic       ei;
    lat = 5'd9; len = 4'd6; req = 2'b01; ph = 2'd1;
    tick();
    req = '0;
    for (int d = 1; d <= 5; d++) begin
      e0 = (d == 3) ? 4'b1100 : (d == 4) ? 4'b1111 : 4'b0000;
      ei = (d == 5);
      vec++; if (tx[3:0] !== e0) begin bad++; $display("FAIL odt_lat_ch0 t+%0d got %b exp %b", d, tx[3:0], e0); end
      vec++; if (tx[7:4] !== 4'b0) begin bad++; $display("FAIL odt_lat_ch1 t+%0d got %b exp 0000", d, tx[7:4]); end
      vec++; if (idle !== ei) begin bad++; $display("FAIL odt_lat_idle t+%0d got %b exp %b", d, idle, ei); end
      tick();
    end
  endtask

  task automatic test_odt_edges();
    logic [3:0] e0;
    // back-to-back requests with zero latency merge into one window
    lat = 5'd0; len = 4'd4; req = 2'b10; ph = 2'd0;
    tick();
    vec++; if (tx !== 8'hF0) begin bad++; $display("FAIL odt_ovl t+1 got %h exp f0", tx); end
    tick();
    req = '0;
    vec++; if (tx !== 8'hF0) begin bad++; $display("FAIL odt_ovl t+2 got %h exp f0", tx); end
    tick();
    vec++; if (tx !== 8'h00 || idle !== 1'b1) begin bad++;
      $display("FAIL odt_ovl t+3 got tx=%h idle=%b exp 00 1", tx, idle); end
    // LEN=0 behaves as a single phase
    len = 4'd0; ph = 2'd3; req = 2'b01;
    tick();
    req = '0;
    vec++; if (tx !== 8'h08) begin bad++; $display("FAIL odt_len0 got %h exp 08", tx); end
    tick();
    vec++; if (tx !== 8'h00) begin bad++; $display("FAIL odt_len0_end got %h exp 00", tx); end
    // maximum latency and length from the last phase
    lat = 5'd31; len = 4'd15; ph = 2'd3; req = 2'b01;
    tick();
    req = '0;
    for (int d = 1; d <= 14; d++) begin
      e0 = (d == 9) ? 4'b1100 : (d >= 10 && d <= 12) ? 4'b1111 : (d == 13) ? 4'b0001 : 4'b0000;
      vec++; if (tx[3:0] !== e0 || tx[7:4] !== 4'b0) begin bad++;
        $display("FAIL odt_max t+%0d got %h exp %h", d, tx, {4'b0, e0}); end
      tick();
    end
  endtask

  task automatic test_odt_random();
    int         n = 0;
    int         maxp = -1;
    int         s, l;
    logic [3:0] en;
    logic       ei;
    for (int c = 0; c < NUM_ODT; c++) for (int i = 0; i < 4096; i++) mark[c][i] = 1'b0;
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    for (int b = 0; b < 6; b++) begin
      lat = LAT_W'($urandom_range(0, 31));
      len = LEN_W'($urandom_range(0, 15));
      for (int k = 0; k < 46; k++) begin
        for (int c = 0; c < NUM_ODT; c++) begin
          for (int bb = 0; bb < 4; bb++) en[bb] = (n >= 1) ? mark[c][4*(n-1)+bb] : 1'b0;
          vec++; if (tx[4*c +: 4] !== en) begin bad++;
            $display("FAIL odt_rand n=%0d ch%0d got %b exp %b", n, c, tx[4*c +: 4], en); end
        end
        ei = (n == 0) || (maxp < 4*(n-1));
        vec++; if (idle !== ei) begin bad++; $display("FAIL odt_rand_idle n=%0d got %b exp %b", n, idle, ei); end
        if (n >= 1) begin
          vec++; if (oe !== 8'hFF) begin bad++; $display("FAIL odt_rand_oe n=%0d got %h exp ff", n, oe); end
        end
        for (int c = 0; c < NUM_ODT; c++) req[c] = (k < 30) && ($urandom_range(0, 3) == 0);
        ph = 2'($urandom_range(0, 3));
        s = 4*n + int'(ph) + int'(lat);
        l = (len == 0) ? 1 : int'(len);
        for (int c = 0; c < NUM_ODT; c++) begin
          if (req[c]) begin
            for (int q = 0; q < l; q++) mark[c][s+q] = 1'b1;
            if (s + l - 1 > maxp) maxp = s + l - 1;
          end
        end
        tick();
        n++;
      end
    end
    req = '0;
  endtask

  // One delay sequence started in cycle 0; optional out-of-range on channel oc after its move om,
  // optional DLY_START spam through the DONE cycle with junk targets.
  task automatic test_delay_seq(input string nm, input int t0, input int t1,
                                input int oc, input int om, input bit harass);
    int tg[NUM_ODT], kc[NUM_ODT];
    bit rng[NUM_ODT], up[NUM_ODT];
    int k = 0, dn, errc = 1 << 30, oors = 1 << 30;
    logic [NUM_ODT-1:0] em, ee;
    tg[0] = t0; tg[1] = t1;
    for (int c = 0; c < NUM_ODT; c++) begin
      rng[c] = tg[c] > int'(MAX_TAP);
      up[c]  = tg[c] > int'(LOAD_TAP);
      kc[c]  = rng[c] ? 0 : (up[c] ? tg[c] - int'(LOAD_TAP) : int'(LOAD_TAP) - tg[c]);
      if (c == oc && om >= 0 && om < kc[c]) begin
        kc[c] = om + 1;
        oors  = 2 + om*(1+S) + 1;
        errc  = 2 + (om+1)*(1+S);
      end
      if (kc[c] > k) k = kc[c];
    end
    dn = 2 + k*(1+S);
    for (int n = 0; n <= dn; n++) begin
      if (n == 0) begin
        vec++; if ({busy, done, load, move} !== '0) begin bad++;
          $display("FAIL %s c0 got busy=%b done=%b load=%b move=%b exp all 0", nm, busy, done, load, move); end
      end else begin
        for (int c = 0; c < NUM_ODT; c++) begin
          em[c] = 1'b0;
          for (int i = 0; i < kc[c]; i++) if (n == 2 + i*(1+S)) em[c] = 1'b1;
          ee[c] = rng[c] || (c == oc && n >= errc);
        end
        vec++; if (load !== ((n == 1) ? 2'b11 : 2'b00)) begin bad++; $display("FAIL %s load c%0d got %b", nm, n, load); end
        vec++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy c%0d got %b exp 1", nm, n, busy); end
        vec++; if (done !== (n == dn)) begin bad++; $display("FAIL %s done c%0d got %b exp %b", nm, n, done, n == dn); end
        vec++; if (move !== em) begin bad++; $display("FAIL %s move c%0d got %b exp %b", nm, n, move, em); end
        vec++; if (err !== ee) begin bad++; $display("FAIL %s err c%0d got %b exp %b", nm, n, err, ee); end
        for (int c = 0; c < NUM_ODT; c++) begin
          if (em[c]) begin
            vec++; if (dir[c] !== up[c]) begin bad++; $display("FAIL %s dir ch%0d c%0d got %b exp %b", nm, c, n, dir[c], up[c]); end
          end
        end
      end
      start = (n == 0) || harass;
      targ  = (n == 0) ? {TAP_W'(t1), TAP_W'(t0)} : (TAP_W*NUM_ODT)'($urandom());
      for (int c = 0; c < NUM_ODT; c++) oor[c] = (c == oc) && (n >= oors);
      tick();
    end
    start = 1'b0; oor = '0; targ = '0;
    vec++; if (busy !== 1'b0 || load !== '0) begin bad++;
      $display("FAIL %s post got busy=%b load=%b exp 0 00", nm, busy, load); end
  endtask

  task automatic test_delay_directed();
    test_delay_seq("inc", 4, 1, -1, -1, 1'b0);
    test_delay_seq("k0", 1, 1, -1, -1, 1'b0);
    test_delay_seq("dec_range", 0, 200, -1, -1, 1'b0);
    test_delay_seq("oor", 5, 3, 0, 0, 1'b0);
    test_delay_seq("busy", 6, 0, -1, -1, 1'b1);
    test_delay_seq("tap_edge", 127, 128, -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_delay_seq("b2b_a", 3, 2, -1, -1, 1'b1);
    test_delay_seq("b2b_b", 2, 5, 1, 1, 1'b0);
  endtask

  task automatic test_delay_random();
    int a, b;
    for (int r = 0; r < 8; r++) begin
      a = ($urandom_range(0, 7) == 0) ? 200 : int'($urandom_range(0, 9));
      b = ($urandom_range(0, 7) == 0) ? 129 : int'($urandom_range(0, 9));
      test_delay_seq("dly_rand", a, b, int'($urandom_range(0, 2)) - 1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_abort();
    lat = 5'd20; len = 4'd5; ph = 2'd0; req = 2'b01;
    start = 1'b1; targ = {8'd10, 8'd10};
    tick();
    req = '0; start = 1'b0; targ = '0;
    tick();
    tick();
    vec++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre busy got %b exp 1", busy); end
    rst = 1'b1;
    tick();
    vec++; if ({busy, done, err, load, move, dir} !== '0) begin bad++;
      $display("FAIL abort_dly got %b exp 0", {busy, done, err, load, move, dir}); end
    vec++; if (tx !== '0 || oe !== '0 || idle !== 1'b1) begin bad++;
      $display("FAIL abort_odt got tx=%h oe=%h idle=%b exp 00 00 1", tx, oe, idle); end
    rst = 1'b0;
    for (int n = 5; n <= 8; n++) begin
      tick();
      vec++; if (tx !== '0 || oe !== 8'hFF || busy !== 1'b0) begin bad++;
        $display("FAIL abort_post c%0d got tx=%h oe=%h busy=%b exp 00 ff 0", n, tx, oe, busy); end
    end
    test_delay_seq("after_abort", 3, 0, -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_odt_latency();
    test_odt_edges();
    test_odt_random();
    test_delay_directed();
    test_back_to_back();
    test_delay_random();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/ddr_odt_lane_ctrl.md
# ddr_odt_lane_ctrl

Parametrised ODT lane controller for the DDR4 PHY block, driving NUM_ODT ODT output IODs in 4:1 transmit mode from FAB_CLK. It converts per-rank ODT requests into serialised 4-bit TX/OE nibbles with programmable latency and pulse length at DRAM-clock (phase) resolution. It also sequences the IOD delay-line LOAD/MOVE/DIRECTION controls to move every channel to a programmed tap, with per-channel out-of-range error capture.

## Interface
- NUM_ODT, 2, number of ODT channels (ranks), 1..4
- LAT_W, 5, width of CFG_ODT_LAT
- LEN_W, 4, width of CFG_ODT_LEN
- TAP_W, 8, tap counter/target width
- LOAD_TAP, 1, tap value after DELAY_LINE_LOAD
- MAX_TAP, 127, highest legal tap
- SETTLE_CYC, 2, idle cycles after each MOVE pulse, >=1
- FAB_CLK  in  1  fabric clock; one cycle = 4 DRAM phases
- TX_SYNC_RST  in  1  reset; synchronous, active-high
- ODT_REQ  in  NUM_ODT  per-channel ODT request, sampled every cycle
- REQ_PHASE  in  2  phase (0..3) within the current cycle at which requests take effect
- CFG_ODT_LAT  in  LAT_W  phases from request to ODT assertion
- CFG_ODT_LEN  in  LEN_W  phases ODT stays high; 0 is treated as 1
- ODT_IDLE  out  1  no ODT pending or active on any channel
- TX_DATA  out  4*NUM_ODT  channel c at [4c+3:4c]; bit 0 is transmitted first
- OE_DATA  out  4*NUM_ODT  output enable nibbles
- DLY_START  in  1  starts a delay sequence; ignored while DLY_BUSY
- DLY_TARGET  in  TAP_W*NUM_ODT  per-channel target tap, sampled on an accepted DLY_START
- DLY_BUSY  out  1  sequence in progress
- DLY_DONE  out  1  one-cycle completion pulse
- DLY_ERR  out  NUM_ODT  sticky per-channel error; cleared by reset or accepted DLY_START
- DELAY_LINE_LOAD  out  NUM_ODT  to IOD
- DELAY_LINE_MOVE  out  NUM_ODT  to IOD
- DELAY_LINE_DIRECTION  out  NUM_ODT  to IOD; 1 = increment
- DELAY_LINE_OUT_OF_RANGE  in  NUM_ODT  from IOD

## Operation
- Reset value of every output is 0, except ODT_IDLE, which is 1. The delay FSM resets to IDLE. The tap counters reset to LOAD_TAP. All pending ODT windows are cleared.
- OE_DATA is 4'b1111 per channel from the first cycle after reset deassertion. The ODT pin is always driven.
- ODT windows:
  - A request on channel c in cycle t at phase p asserts ODT over absolute phases 4t+p+LAT through 4t+p+LAT+LEN-1.
  - Each channel keeps a registered pending-phase vector covering at least 3+2^LAT_W-1+2^LEN_W-1 phases.
  - Overlapping or adjacent windows are ORed, which extends the assertion.
  - CFG_ODT_LAT and CFG_ODT_LEN may change only while ODT_IDLE=1. Behaviour is otherwise undefined.
- Delay FSM states: IDLE, LOAD, STEP, GAP, DONE.
  - IDLE -> LOAD on DLY_START. Targets are latched and DLY_ERR is cleared.
  - LOAD: DELAY_LINE_LOAD is pulsed on all channels and the tap counters are set to LOAD_TAP. Next state is STEP.
  - LOAD, target check: any channel with target > MAX_TAP sets DLY_ERR and is excluded from moves.
  - STEP, when channels need to move: each non-errored channel with cur != target gets a one-cycle MOVE pulse. DIRECTION is 1 if target > cur, else 0, and is held for the pulse. The counter then moves by ±1. Next state is GAP.
  - STEP, when no channel needs to move: go to DONE.
  - GAP: lasts SETTLE_CYC cycles, with DIRECTION held. OUT_OF_RANGE is sampled in the last GAP cycle. A channel that reads 1 sets DLY_ERR and stops moving. Next state is STEP.
  - DONE: DLY_DONE pulses. Next state is IDLE.
- All channels move in parallel. Sequence length is set by the largest remaining |target - LOAD_TAP|.

## Timing
- ODT latency: absolute phase P is output in cycle floor(P/4)+1, at bit P mod 4. This is one register stage.
- Delay FSM timing, with DLY_START accepted in cycle 0:
  - LOAD pulse in cycle 1; DLY_BUSY high from cycle 1 through the DONE cycle inclusive.
  - With k = max moves and S = SETTLE_CYC, MOVE pulses occur in cycles 2+i(1+S) for i = 0..k-1, and DLY_DONE occurs in cycle 2+k(1+S).
  - k=0 gives DLY_DONE in cycle 2.
- DLY_START in the DONE cycle is ignored; it is accepted from the following IDLE cycle.
- Reset mid-operation aborts immediately, with no DONE pulse. All MOVE/LOAD outputs are 0 in the cycle after reset is asserted.

## Test plan
- ODT latency and length: LAT=9, LEN=6, ODT_REQ[0]=1 at cycle t, phase 1 -> ch0 TX_DATA = 4'b1100 at t+3, 4'b1111 at t+4, 0 at t+5. Ch1 stays 0. ODT_IDLE returns to 1 at t+5.
- Overlap and edge cases: LAT=0, LEN=4, ch1 requests at cycles t and t+1, phase 0 -> 4'b1111 at t+1 and t+2, then 0. LEN=0 yields a single phase.
- Delay increment: NUM_ODT=2, S=2, targets {4,1}, LOAD_TAP=1:
  - LOAD at cycle 1.
  - ch0 MOVE at cycles 2, 5, 8 with DIRECTION=1; ch1 has no MOVE.
  - DLY_DONE at cycle 11; DLY_ERR=0.
- Decrement, range check, and hardware error:
  - Target 0 -> one MOVE with DIRECTION=0.
  - Target 200 -> DLY_ERR set in cycle 1, and no MOVE on that channel.
  - OUT_OF_RANGE forced high in the first GAP -> DLY_ERR=1 and only one MOVE on that channel.
- Reset and busy handling: reset asserted during GAP -> all outputs at reset values in the next cycle, FSM in IDLE. DLY_START while DLY_BUSY -> no effect on targets or timing.
